// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: op code constants and FSM state encoding.
package alu_pkg;

  localparam logic [2:0] OpAnd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAdd = 3'b010;
  localparam logic [2:0] OpDiv = 3'b011;
  localparam logic [2:0] OpMul = 3'b100;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StIssue = 2'b01,
    StResp  = 2'b10
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way grant selection: a lone requester wins, a tie goes to the pointed-at port.
module rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_ptr,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req == 2'b11) begin
      o_gnt = i_ptr ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters, one operation per
// IDLE -> ISSUE -> RESP pass, with round-robin arbitration on ties.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a_in,
  output logic [WIDTH-1:0] alu_b_in,
  output logic [OP_W-1:0]  alu_operation,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  state_e           r_state;
  state_e           w_state_next;
  logic             r_ptr;
  logic             r_port;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [OP_W-1:0]  r_op;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_err;

  logic [1:0]       w_gnt;
  logic             w_force_err;
  logic             w_rsp_hs;

  rr_arb2 u_rr_arb2 (
    .i_req ({req1_valid, req0_valid}),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt)
  );

  // Unsupported op codes and divide-by-zero bypass the ALU entirely.
  assign w_force_err = (r_op > OP_W'(OpMul)) || ((r_op == OP_W'(OpDiv)) && (r_b == '0));
  assign w_rsp_hs    = r_port ? rsp1_ready : rsp0_ready;

  assign rsp_result = r_result;
  assign rsp_zero   = r_zero;
  assign rsp_err    = r_err;

  always_comb begin
    w_state_next  = r_state;
    req0_ready    = 1'b0;
    req1_ready    = 1'b0;
    rsp0_valid    = 1'b0;
    rsp1_valid    = 1'b0;
    alu_a_in      = '0;
    alu_b_in      = '0;
    alu_operation = OP_W'(OpAdd);
    unique case (r_state)
      StIdle: begin
        // Gate with reset so a held request is never acknowledged while in reset.
        req0_ready = w_gnt[0] & ~reset;
        req1_ready = w_gnt[1] & ~reset;
        if (|w_gnt) w_state_next = StIssue;
      end
      StIssue: begin
        alu_a_in      = r_a;
        alu_b_in      = r_b;
        alu_operation = r_op;
        w_state_next  = StResp;
      end
      StResp: begin
        rsp0_valid = ~r_port;
        rsp1_valid = r_port;
        if (w_rsp_hs) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_ptr    <= 1'b0;
      r_port   <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        StIdle: begin
          if (|w_gnt) begin
            r_port <= w_gnt[1];
            r_a    <= w_gnt[1] ? req1_a  : req0_a;
            r_b    <= w_gnt[1] ? req1_b  : req0_b;
            r_op   <= w_gnt[1] ? req1_op : req0_op;
          end
        end
        StIssue: begin
          r_result <= w_force_err ? '0 : alu_result;
          r_zero   <= w_force_err | alu_zero;
          r_err    <= w_force_err;
        end
        StResp: begin
          if (w_rsp_hs) r_ptr <= ~r_port;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter WIDTH, default 64, sets the operand and result width in bits.
REQ-002 Parameter OP_W, default 3, sets the ALU operation code width in bits.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-006 reqN_ready  output  1  (N=0,1) arbiter accepts requester N's operation this cycle.
REQ-007 reqN_a, reqN_b  input  WIDTH  (N=0,1) operands.
REQ-008 reqN_op  input  OP_W  (N=0,1) operation code.
REQ-009 rspN_valid  output  1  (N=0,1) response for requester N is valid.
REQ-010 rspN_ready  input  1  (N=0,1) requester N consumes the response.
REQ-011 rsp_result  output  WIDTH  shared result bus, meaningful only when a rspN_valid is high.
REQ-012 rsp_zero  output  1  zero flag.
REQ-013 rsp_err  output  1  error flag.
REQ-014 alu_a_in, alu_b_in  output  WIDTH  operands driven to the ALU.
REQ-015 alu_operation  output  OP_W  operation code driven to the ALU.
REQ-016 alu_result  input  WIDTH  combinational ALU result.
REQ-017 alu_zero  input  1  combinational ALU zero flag.

Function
REQ-018 The arbiter SHALL share one combinational ALU between two requesters using a three-state FSM: IDLE, ISSUE, RESP.
REQ-019 In IDLE, a single valid requester SHALL be granted.
REQ-020 In IDLE with both requesters valid, the port named by the round-robin pointer SHALL be granted.
REQ-021 In IDLE, reqN_ready SHALL be asserted combinationally for the granted port only, and only when that port's reqN_valid is high.
REQ-022 On the accept edge, the arbiter SHALL register the granted port's operands, op code and port id, then enter ISSUE.
REQ-023 In ISSUE, alu_a_in, alu_b_in and alu_operation SHALL be driven from the registered values.
REQ-024 At the end of ISSUE, alu_result and alu_zero SHALL be registered and the FSM SHALL enter RESP.
REQ-025 In RESP, rspN_valid SHALL be high for the granted port only.
REQ-026 In RESP, rsp_result, rsp_zero and rsp_err SHALL hold stable until rspN_ready is high.
REQ-027 On the edge where rspN_valid and rspN_ready are both high, the FSM SHALL return to IDLE and the pointer SHALL move to the other port.
REQ-028 Latency SHALL be exactly 2 cycles from the accept edge to the first rspN_valid cycle.
REQ-029 Peak throughput SHALL be one operation per 3 cycles.
REQ-030 Supported op codes SHALL be: 000 AND, 001 SUB, 010 ADD, 011 DIV, 100 MUL.
REQ-031 Op codes 101, 110 and 111 SHALL produce rsp_result=0, rsp_zero=1, rsp_err=1, and the ALU result SHALL be ignored.
REQ-032 DIV with b=0 SHALL produce rsp_result=0, rsp_zero=1, rsp_err=1 without using alu_result.
REQ-033 For all other operations, rsp_err SHALL be 0.
REQ-034 A reqN_valid deasserted before acceptance SHALL NOT be granted.
REQ-035 Requests arriving in ISSUE or RESP SHALL wait with ready low; they SHALL NOT be dropped.
REQ-036 When idle, alu_a_in and alu_b_in SHALL be 0 and alu_operation SHALL be 010.

Reset
REQ-037 Reset SHALL force the FSM to IDLE and the pointer to port 0.
REQ-038 Reset SHALL drive all registered operands and results to 0.
REQ-039 During reset, rspN_valid and reqN_ready SHALL be 0.
REQ-040 Reset asserted mid-ISSUE or mid-RESP SHALL abandon the in-flight operation, and no response SHALL be issued afterwards.

Structure
REQ-041 Op code constants and the FSM state encoding SHALL reside in a shared package, alu_pkg.
REQ-042 Grant selection SHALL be a separate sub-module, rr_arb2: two request inputs, one pointer input, one-hot grant output.
REQ-043 The ALU SHALL be instantiated outside this block.

Verification
REQ-044 Req0 a=5, b=6, op=010 -> rsp0_valid 2 cycles after accept; result=11, zero=0, err=0.
REQ-045 Both ports valid after reset (req0: 8*7, op 100; req1: 10-7, op 001) -> port 0 first with result 56, then port 1 with result 3, pointer ending at 0.
REQ-046 Req1 a=40, b=8, op=011 with rsp1_ready held low for 5 cycles -> result 5 stable throughout, and req0 ready stays low.
REQ-047 Req0 a=40, b=0, op=011 -> result=0, zero=1, err=1; op=111 -> result=0, err=1.
REQ-048 Reset asserted during ISSUE -> no rspN_valid ever appears; the next req1 after reset is granted with latency 2.
REQ-049 Req0 a=7, b=7, op=001 -> result=0, zero=1, err=0.
